// File: rtl/signed_accumulator_with_overflow.sv
// signed_accumulator_with_overflow
// Signed two's-complement accumulator with per-add overflow detection,
// a sticky overflow flag and a saturating sample counter.
// Optional feature macro: SATURATE_EN. When defined, an overflowing add clamps
// the accumulator to the signed max/min. When undefined, the result wraps.
module signed_accumulator_with_overflow #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     sum,
  output logic                 overflow,
  output logic                 overflow_sticky,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0]     MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]     MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH:0]   add_full;
  logic             add_ovf;
  logic [WIDTH-1:0] acc_next;

  // Sign-extended add; the two top bits disagree exactly when the
  // WIDTH-bit signed result has overflowed (equal operand signs, flipped result sign).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_next = '0;
    add_full = {acc[WIDTH-1], acc} + {in_data[WIDTH-1], in_data};
    add_ovf  = add_full[WIDTH] ^ add_full[WIDTH-1];
    acc_next = add_full[WIDTH-1:0];
`ifdef SATURATE_EN
    // On overflow both operands share the sign of acc, so it tells the direction.
    if (add_ovf) acc_next = acc[WIDTH-1] ? MIN_VAL : MAX_VAL;
`endif
  end

  // Accumulator state and registered outputs; priority is rst, clear, in_valid.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      acc             <= '0;
      out_valid       <= 1'b0;
      overflow        <= 1'b0;
      overflow_sticky <= 1'b0;
      count           <= '0;
    end else if (clear) begin
      // A clear with a sample loads it as 0 + in_data, which cannot overflow.
      overflow_sticky <= 1'b0;
      overflow        <= 1'b0;
      out_valid       <= in_valid;
      acc             <= in_valid ? in_data : '0;
      count           <= in_valid ? CNT_ONE : '0;
    end else if (in_valid) begin
      acc             <= acc_next;
      out_valid       <= 1'b1;
      overflow        <= add_ovf;
      overflow_sticky <= overflow_sticky | add_ovf;
      if (count != CNT_MAX) count <= count + CNT_ONE;
    end else begin
      out_valid <= 1'b0;
      overflow  <= 1'b0;
    end
  end

  assign sum = acc;

endmodule

// File: tb/tb_signed_accumulator_with_overflow.sv
// Testbench for signed_accumulator_with_overflow (WIDTH=4, CNT_WIDTH=2).
// Directed scenarios followed by randomized traffic, all compared against an
// integer-arithmetic reference model.
module tb_signed_accumulator_with_overflow;

  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int SMAX = (1 << (W - 1)) - 1;
  localparam int SMIN = -(1 << (W - 1));
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic [W-1:0]  sum;
  logic          overflow;
  logic          overflow_sticky;
  logic [CW-1:0] count;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model state, kept as plain integers.
  int m_acc = 0;
  int m_cnt = 0;
  bit m_sticky = 0;
  bit m_valid = 0;
  bit m_ovf = 0;

  signed_accumulator_with_overflow #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .sum(sum), .overflow(overflow),
    .overflow_sticky(overflow_sticky), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour from the arithmetic rules, not the RTL structure.
  task automatic model(input bit r, input bit c, input bit v, input int d);
    int s;
    bit o;
    if (r) begin
      m_acc = 0; m_cnt = 0; m_sticky = 0; m_valid = 0; m_ovf = 0;
    end else if (c) begin
      m_sticky = 0; m_ovf = 0; m_valid = v;
      m_acc = v ? d : 0;
      m_cnt = v ? 1 : 0;
    end else if (v) begin
      s = m_acc + d;
      o = (s > SMAX) || (s < SMIN);
      if (o) begin
`ifdef SATURATE_EN
        s = (s > SMAX) ? SMAX : SMIN;
`else
        s = (s > SMAX) ? s - (1 << W) : s + (1 << W);
`endif
      end
      m_acc = s;
      m_sticky = m_sticky | o;
      m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
      m_valid = 1; m_ovf = o;
    end else begin
      m_valid = 0; m_ovf = 0;
    end
  endtask

  function automatic int to_signed(input logic [W-1:0] x);
    return x[W-1] ? int'(x) - (1 << W) : int'(x);
  endfunction

  // Drive one cycle of inputs, advance the model and compare every output.
  task automatic cycle(input bit r, input bit c, input bit v, input int d);
    @(negedge clk);
    rst = r; clear = c; in_valid = v; in_data = W'(d);
    @(posedge clk);
    model(r, c, v, d);
    #1;
    check("out_valid", int'(out_valid), int'(m_valid));
    check("sum", to_signed(sum), m_acc);
    check("overflow", int'(overflow), int'(m_ovf));
    check("overflow_sticky", int'(overflow_sticky), int'(m_sticky));
    check("count", int'(count), m_cnt);
  endtask

  initial begin
    int d;
    bit r, c, v;

    // Reset, then 1, 2, -1, then reset again.
    cycle(1, 0, 0, 0);
    check("reset_sum", to_signed(sum), 0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 2);
    cycle(0, 0, 1, -1);
    check("seq_sum3", to_signed(sum), 2);
    check("seq_cnt3", int'(count), 3);
    cycle(1, 0, 1, 5);
    check("rst_mid_sum", to_signed(sum), 0);
    check("rst_mid_valid", int'(out_valid), 0);

    // Positive overflow: 4 then 7.
    cycle(0, 0, 1, 4);
    cycle(0, 0, 1, 7);
`ifdef SATURATE_EN
    check("pos_ovf_sum", to_signed(sum), 7);
`else
    check("pos_ovf_sum", to_signed(sum), -5);
`endif
    check("pos_ovf_flag", int'(overflow), 1);

    // Negative overflow: -4 then -7, after a clear.
    cycle(0, 1, 0, 0);
    check("clear_alone_valid", int'(out_valid), 0);
    check("clear_alone_sticky", int'(overflow_sticky), 0);
    cycle(0, 0, 1, -4);
    cycle(0, 0, 1, -7);
`ifdef SATURATE_EN
    check("neg_ovf_sum", to_signed(sum), -8);
`else
    check("neg_ovf_sum", to_signed(sum), 5);
`endif
    check("neg_ovf_sticky", int'(overflow_sticky), 1);

    // Clear together with in_valid=2 while sticky is set.
    cycle(0, 1, 1, 2);
    check("clear_load_sum", to_signed(sum), 2);
    check("clear_load_cnt", int'(count), 1);
    check("clear_load_sticky", int'(overflow_sticky), 0);

    // No-overflow sequence 7, -4, 3, -3 from a clean start.
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 7);
    cycle(0, 0, 1, -4);
    cycle(0, 0, 1, 3);
    cycle(0, 0, 1, -3);
    check("no_ovf_sum", to_signed(sum), 3);
    check("no_ovf_sticky", int'(overflow_sticky), 0);

    // Counter saturation with six zero samples.
    cycle(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 0);
    check("cnt_sat", int'(count), 3);

    // Idle hold.
    cycle(0, 0, 0, 0);
    check("idle_valid", int'(out_valid), 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 99) < 2);
      c = ($urandom_range(0, 99) < 8);
      v = ($urandom_range(0, 99) < 75);
      d = int'($urandom_range(0, (1 << W) - 1));
      if (d > SMAX) d = d - (1 << W);
      cycle(r, c, v, d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/signed_accumulator_with_overflow.md
# signed_accumulator_with_overflow

Parametrised signed two's-complement accumulator with per-add overflow detection, a sticky overflow flag and a sample counter. Each accepted input is added to a running sum held in a register; the block reports whether that add overflowed the WIDTH-bit signed range. It sits in the arithmetic datapath wherever a stream of signed samples is summed, for example in filters, averaging and DC-offset estimation. Optional saturation clamps the sum instead of wrapping it.

## Interface
- WIDTH, 8: data and accumulator width in bits, signed two's complement, minimum 2.
- CNT_WIDTH, 8: sample counter width in bits, minimum 1.

- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous restart of accumulation; no handshake needed.
- in_valid  input  1  in_data is presented this cycle and is accepted unconditionally.
- in_data  input  WIDTH  signed sample.
- out_valid  output  1  one-cycle pulse; sum reflects an accepted sample.
- sum  output  WIDTH  signed accumulator value, registered.
- overflow  output  1  the add reported by this out_valid pulse overflowed; qualified by out_valid.
- overflow_sticky  output  1  at least one overflow since the last reset or clear.
- count  output  CNT_WIDTH  number of samples accepted since the last reset or clear; saturates at all-ones.

## Operation
- Each cycle the next accumulator value is computed as acc + in_data in WIDTH+1 bits; the result is the low WIDTH bits.
- Overflow for an add means acc and in_data have equal sign bits and the result sign differs. Operands of opposite sign never overflow.
- Priority per cycle: rst, then clear, then in_valid.
- rst: all state and outputs return to their reset values; any in_valid or clear in the same cycle is ignored.
- clear without in_valid: acc=0, count=0, overflow_sticky=0; next cycle out_valid=0; sum reads 0.
- clear with in_valid: acc=in_data (load, treated as 0 + in_data, which cannot overflow), count=1, overflow_sticky=0; next cycle out_valid=1, overflow=0.
- in_valid alone: acc updates; count increments unless already all-ones; overflow_sticky is ORed with this add's overflow.
- No in_valid and no clear: all state holds; out_valid=0 and overflow=0.
- overflow is 0 whenever out_valid is 0.

## Timing
- Reset values: sum=0, out_valid=0, overflow=0, overflow_sticky=0, count=0; the internal acc is also 0.
- Latency is 1 cycle. An input accepted at edge N appears on sum, out_valid, overflow and count after edge N. overflow_sticky rises in that same cycle.
- Full throughput: a new sample can be accepted every cycle, with no stall and no backpressure.
- Back-to-back samples chain. The sample at N+1 is added to the result from N, including any wrapped or clamped value.
- count wrap: when count is at all-ones it stays at all-ones. Accumulation continues.
- A reset or clear asserted in the middle of a stream takes effect at that edge. The next sample starts from 0.

## Configuration
- SATURATE_EN undefined: on overflow, acc takes the wrapped low WIDTH bits, which is plain modular arithmetic.
- SATURATE_EN defined: on overflow, acc is clamped. Positive overflow gives the maximum (2^(WIDTH-1))-1; negative overflow gives the minimum -2^(WIDTH-1). The overflow and overflow_sticky behaviour is identical in both modes.

## Test plan
- Reset, then WIDTH=4, inputs 1, 2, -1 on consecutive cycles, then rst=1 for one cycle: out_valid pulses on three consecutive cycles with sum 1, 3, 2 and count 1, 2, 3; after the reset edge sum=0, count=0 and all flags 0.
- WIDTH=4, inputs 4 then 7: the second add overflows, so overflow=1 on that pulse and overflow_sticky=1. Without SATURATE_EN sum=-5 (4'b1011); with SATURATE_EN sum=7.
- WIDTH=4, inputs -4 then -7: the second add overflows negatively. Without SATURATE_EN sum=5; with SATURATE_EN sum=-8.
- WIDTH=4, inputs 7, -4, 3, -3: no add overflows, so overflow=0 on every pulse and overflow_sticky stays 0; sum sequence 7, 3, 6, 3.
- After a sticky overflow, clear asserted together with in_valid=2: next cycle sum=2, count=1, overflow=0, overflow_sticky=0. A second case asserts clear alone: next cycle sum=0 and out_valid=0.
- CNT_WIDTH=2, six consecutive inputs of 0: count goes 1, 2, 3, 3, 3, 3 and sum stays 0.
